// File: rtl/lsh_pkg.sv
// rtl/lsh_pkg.sv - shared widths, types and FSM states for the LSH ROM fetch path
package lsh_pkg;

  localparam int ADDR_W        = 24;
  localparam int DATA_W        = 88;
  localparam int LSH_ROM_DEPTH = 9622800;

  typedef logic [ADDR_W-1:0] lsh_addr_t;
  typedef logic [DATA_W-1:0] lsh_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } lsh_fetch_state_e;

endpackage

// File: rtl/lsh_skid_fifo.sv
// rtl/lsh_skid_fifo.sv - 2-entry {data, last} skid FIFO; the head entry is a plain register
module lsh_skid_fifo #(
  parameter int WIDTH = 88
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_last,
  output logic             full,
  output logic             empty,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] tail_data;
  logic             tail_last;
  logic [1:0]       cnt;

  assign full      = (cnt == 2'd2);
  assign empty     = (cnt == 2'd0);
  assign occupancy = cnt;

  // Entries shift toward the head so the output side never goes through a read mux.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            head_data <= push_data;
            head_last <= push_last;
            cnt       <= 2'd1;
          end else if (cnt == 2'd1) begin
            tail_data <= push_data;
            tail_last <= push_last;
            cnt       <= 2'd2;
          end
        end
        2'b01: begin
          if (cnt != 2'd0) begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_last <= 1'b0;
            cnt       <= cnt - 2'd1;
          end
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= push_data;
            tail_last <= push_last;
          end else begin
            head_data <= push_data;
            head_last <= push_last;
            cnt       <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lsh_rom_fetch_ctrl.sv
// rtl/lsh_rom_fetch_ctrl.sv - LSH ROM range fetch sequencer with skid-buffered output stream
// Optional: LSH_FETCH_PERF_EN adds the perf_stall_cycles counter output.
module lsh_rom_fetch_ctrl #(
  parameter int ADDR_W    = lsh_pkg::ADDR_W,
  parameter int DATA_W    = lsh_pkg::DATA_W,
  parameter int ROM_DEPTH = lsh_pkg::LSH_ROM_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              rom_me,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef LSH_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles
`endif
);

  import lsh_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(ROM_DEPTH);

  lsh_fetch_state_e state, state_nx;

  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] rem;
  logic              inflight;
  logic              inflight_last;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic [ADDR_W:0]   cmd_end;
  logic              range_bad;
  logic              len_zero;
  logic              pop;
  logic              issue;
  logic              credit_ok;
  logic              drained;
  logic              last_issue;
  logic [2:0]        credit_use;
  logic [1:0]        occ;
  logic              fifo_full;
  logic              fifo_empty;

  assign accept     = cmd_valid && cmd_ready;
  assign cmd_end    = {1'b0, cmd_base} + {1'b0, cmd_len};
  assign range_bad  = (cmd_end > DEPTH_X);
  assign len_zero   = (cmd_len == '0);
  assign pop        = out_valid && out_ready;
  assign out_valid  = !fifo_empty;

  // Slots held = buffered words + the read in flight; a same-cycle pop frees one.
  assign credit_use = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign credit_ok  = fifo_full ? (pop && !inflight) : (credit_use < 3'd2);
  assign issue      = !reset && (state == FETCH) && (rem != '0) && credit_ok;
  assign last_issue = issue && (rem == ADDR_W'(1));
  assign drained    = !inflight && fifo_empty;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !range_bad && !len_zero) state_nx = FETCH;
      FETCH:   if (last_issue) state_nx = DRAIN;
      DRAIN:   if (drained) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    rom_me    = issue;
    rom_addr  = issue ? cur : '0;
    done      = done_q;
    case (state)
      IDLE: begin
        cmd_ready = !reset;
        busy      = 1'b0;
      end
      DRAIN:   done = drained && !reset;
      default: ;
    endcase
  end

  assign err = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cur           <= '0;
      rem           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
      done_q        <= accept && !range_bad && len_zero;
      err_q         <= accept && range_bad;
      if (accept) begin
        cur <= cmd_base;
        rem <= cmd_len;
      end else if (issue) begin
        cur <= cur + ADDR_W'(1);
        rem <= rem - ADDR_W'(1);
      end
    end
  end

  lsh_skid_fifo #(
    .WIDTH (DATA_W)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .push_data (rom_q),
    .push_last (inflight_last),
    .pop       (pop),
    .head_data (out_data),
    .head_last (out_last),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occ)
  );

`ifdef LSH_FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset || accept) begin
      perf_stall_cycles <= '0;
    end else if (out_valid && !out_ready && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsh_rom_fetch_ctrl.sv
// tb/tb_lsh_rom_fetch_ctrl.sv - directed table-driven bench for lsh_rom_fetch_ctrl
module tb_lsh_rom_fetch_ctrl;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_base;
  logic [23:0] cmd_len;
  logic        rom_me;
  logic [23:0] rom_addr;
  logic [87:0] rom_q;
  logic        out_valid;
  logic        out_ready;
  logic [87:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;
`ifdef LSH_FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  int n_checks;
  int n_fail;

  lsh_rom_fetch_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .rom_me    (rom_me),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef LSH_FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [87:0] rom_word(input logic [23:0] a);
    return {8'h5A, a, ~a, 8'hC3, a ^ 24'h35A9E1};
  endfunction

  // One-cycle-latency ROM model
  always @(posedge clock) begin
    if (rom_me) rom_q <= rom_word(rom_addr);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int t);
    case (mode)
      0:       return 1'b1;
      1:       return (t % 3) == 0;
      default: return t >= 7;
    endcase
  endfunction

  task automatic start_cmd(input logic [23:0] base, input logic [23:0] len);
    int w;
    w = 0;
    @(negedge clock);
    cmd_base  = base;
    cmd_len   = len;
    cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && w < 50) begin
      @(negedge clock);
      #1;
      w++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // Runs one command to completion; t=0 is the first sample after the accept edge.
  task automatic run_cmd(input logic [23:0] base, input logic [23:0] len, input int mode,
                         output int words, output int reads, output bit got_done, output bit got_err);
    int t, first_valid, first_me, last_me, last_hs, done_t, k;
    bit fin, prev_stall;
    logic [88:0] prev;
    t = 0; first_valid = -1; first_me = 0; last_me = 0; last_hs = 0; done_t = 0; k = 0;
    fin = 0; prev_stall = 0; prev = '0;
    reads = 0; got_done = 0; got_err = 0;
    start_cmd(base, len);
    while (!fin && t < 300) begin
      out_ready = rdy(mode, t);
      #1;
      if (rom_me) begin
        chk("rom_addr", rom_addr, base + 24'(reads));
        chk("credit", ((reads - k - int'(out_valid && out_ready)) < 2), 1);
        if (reads == 0) first_me = t;
        last_me = t;
        reads++;
      end
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_last, out_data}, prev);
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = t;
        chk("last_flag", out_last, (k == int'(len) - 1));
        if (out_ready) begin
          chk("data", out_data, rom_word(base + 24'(k)));
          k++;
          last_hs = t;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev = {out_last, out_data};
      if (done || err) begin
        chk("done_err_excl", done && err, 0);
        got_done = done;
        got_err  = err;
        done_t   = t;
        fin      = 1;
      end else begin
        t++;
        @(negedge clock);
      end
    end
    if (!fin) chk("cmd_timeout", 0, 1);
    words = k;
    if (got_done && k > 0) chk("done_gap", done_t - last_hs, 1);
    if (mode == 0 && len != 0 && got_done) begin
      chk("first_latency", first_valid, 2);
      chk("rom_me_consecutive", last_me - first_me + 1, int'(len));
    end
    @(negedge clock);
    #1;
    chk("cmd_ready_after", cmd_ready, 1);
  endtask

  typedef struct {
    logic [23:0] base;
    logic [23:0] len;
    int          mode;
    bit          exp_err;
    int          exp_words;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    int words, reads, hs, w, t, accepts, lasts, ndone, done_t, idx;
    bit gd, ge;

    vecs[0] = '{24'h000100, 24'd4,  0, 1'b0, 4};
    vecs[1] = '{24'h000010, 24'd8,  1, 1'b0, 8};
    vecs[2] = '{24'h000000, 24'd0,  0, 1'b0, 0};
    vecs[3] = '{24'd9622799, 24'd1, 0, 1'b0, 1};
    vecs[4] = '{24'd9622799, 24'd2, 0, 1'b1, 0};
    vecs[5] = '{24'd9622800, 24'd0, 0, 1'b0, 0};
    vecs[6] = '{24'hFFFFFF, 24'd1,  0, 1'b1, 0};
    vecs[7] = '{24'd9622790, 24'd10, 1, 1'b0, 10};

    n_checks = 0; n_fail = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; out_ready = 1'b0; rom_q = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rom_me", rom_me, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_outs", {rom_addr, out_last, done, err}, 0);

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].base, vecs[i].len, vecs[i].mode, words, reads, gd, ge);
      chk($sformatf("vec%0d_words", i), words, vecs[i].exp_words);
      chk($sformatf("vec%0d_reads", i), reads, vecs[i].exp_words);
      chk($sformatf("vec%0d_err", i), ge, vecs[i].exp_err);
      chk($sformatf("vec%0d_done", i), gd, !vecs[i].exp_err);
    end

    // Reset in the middle of a long command
    start_cmd(24'd0, 24'd100);
    out_ready = 1'b1;
    hs = 0; w = 0;
    while (hs < 10 && w < 100) begin
      #1;
      if (out_valid && out_ready) hs++;
      @(negedge clock);
      w++;
    end
    chk("mid_hs_count", hs, 10);
    reset = 1'b1;
    #1;
    chk("mid_rst_me_gated", rom_me, 0);
    @(negedge clock);
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rom_me", rom_me, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid_rel_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      chk("mid_quiet", {out_valid, rom_me, busy}, 0);
    end
    run_cmd(24'h000020, 24'd2, 0, words, reads, gd, ge);
    chk("mid_next_words", words, 2);
    chk("mid_next_done", gd, 1);

    // Back-to-back: cmd_valid held across two commands
    @(negedge clock);
    cmd_base = 24'h40; cmd_len = 24'd3; cmd_valid = 1'b1; out_ready = 1'b1;
    t = 0; accepts = 0; lasts = 0; ndone = 0; done_t = -10; idx = 0;
    while (ndone < 2 && t < 60) begin
      if (accepts == 1) begin cmd_base = 24'h80; cmd_len = 24'd2; end
      if (accepts == 2) cmd_valid = 1'b0;
      #1;
      if (cmd_valid && cmd_ready) begin
        if (accepts == 1) chk("b2b_accept_after_done", t, done_t + 1);
        accepts++;
      end
      if (out_valid && out_ready) begin
        chk("b2b_data", out_data, rom_word(idx < 3 ? 24'(24'h40 + idx) : 24'(24'h80 + idx - 3)));
        if (out_last) lasts++;
        idx++;
      end
      if (done) begin
        ndone++;
        done_t = t;
      end
      @(negedge clock);
      t++;
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", accepts, 2);
    chk("b2b_lasts", lasts, 2);
    chk("b2b_words", idx, 5);
    chk("b2b_dones", ndone, 2);

`ifdef LSH_FETCH_PERF_EN
    run_cmd(24'h000200, 24'd4, 2, words, reads, gd, ge);
    chk("perf_words", words, 4);
    chk("perf_stall_cycles", perf_stall_cycles, 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/lsh_rom_fetch_ctrl.md
Name: lsh_rom_fetch_ctrl

Overview:
Sequencer that reads contiguous ranges of LSH hash-table words out of the LSH ROM and delivers them as a valid/ready stream to the reuse datapath. It accepts one command at a time, made of a base address and a word count. It drives the ROM memory-enable and address, absorbs the ROM's 1-cycle read latency, and honours downstream backpressure through a 2-entry skid buffer. It sits between the layer-control logic and the LSH ROM.

Parameters:
ADDR_W, 24, ROM word-address width
DATA_W, 88, ROM word width
ROM_DEPTH, 9622800, number of valid ROM words; legal addresses are 0..ROM_DEPTH-1

Ports:
clock  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_base  in  ADDR_W  first word address
cmd_len  in  ADDR_W  number of words to fetch
rom_me  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM read address
rom_q  in  DATA_W  ROM read data, valid the cycle after rom_me
out_valid  out  1  stream word available
out_ready  in  1  consumer accepts the word
out_data  out  DATA_W  fetched word
out_last  out  1  marks the final word of the command
busy  out  1  high whenever the state is not IDLE
done  out  1  1-cycle pulse when a command completes
err  out  1  1-cycle pulse when a command is rejected for being out of range

Behaviour:
- Reset values: cmd_ready=0 during reset and 1 on the first cycle after it; rom_me=0; rom_addr=0; out_valid=0; out_last=0; busy=0; done=0; err=0. The skid buffer is emptied, the in-flight flag is cleared, and the state returns to IDLE.
- Reset mid-operation aborts the command immediately. No further ROM reads are issued, and any read already in flight is discarded.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch base and len.
    - If cmd_base+cmd_len > ROM_DEPTH (computed at ADDR_W+1 bits): go to IDLE, pulse err on the next cycle, issue no reads.
    - Else if cmd_len==0: pulse done on the next cycle, stay in IDLE.
    - Else go to FETCH.
  - FETCH: issue a read (rom_me=1, rom_addr=cur) in any cycle where credit is available.
    - Credit is available when skid occupancy + in-flight read, minus the pop occurring this cycle, is less than 2.
    - Each issue increments cur and decrements remaining.
    - When the last read issues, go to DRAIN.
  - DRAIN: wait until the in-flight read has landed and the skid buffer is empty. On that cycle pulse done and go to IDLE. cmd_ready rises on the cycle after done.
- Read latency: rom_q is captured into the skid buffer exactly 1 cycle after rom_me. There is at most one outstanding read.
- Throughput: with out_ready held high, one word per cycle after a first-word latency of 2 cycles (command accept to out_valid).
- Stream rules:
  - out_valid/out_data/out_last are registered.
  - Once out_valid is asserted, out_data and out_last stay stable until the handshake completes.
  - out_last=1 only on the final word of the command.
- Simultaneous push and pop on a full skid buffer is legal; occupancy is unchanged.
- No address wrap-around is possible: out-of-range commands are rejected before any read.
- done and err are never asserted together.

Optional Feature:
LSH_FETCH_PERF_EN
- Defined: adds output perf_stall_cycles (32 bits). It counts the cycles in which out_valid=1 and out_ready=0, saturates at 0xFFFFFFFF, and clears on reset and on each command accept.
- Undefined: the port and the counter are absent, with no other change in behaviour.

Decomposition:
- Package lsh_pkg holds:
  - ADDR_W, DATA_W, LSH_ROM_DEPTH constants
  - typedef lsh_addr_t (logic [ADDR_W-1:0])
  - typedef lsh_word_t (logic [DATA_W-1:0])
  - enum lsh_fetch_state_e {IDLE, FETCH, DRAIN}
- Sub-module lsh_skid_fifo: 2-entry FIFO of {data, last} with push/pop, full/empty and occupancy outputs. The controller keeps the FSM and credit logic.

Test Plan:
- Streaming: base=0x000100, len=4, out_ready=1. Expect rom_addr 0x100..0x103 on 4 consecutive cycles, out_data equal to ROM[0x100..0x103], out_last on the 4th word, done 1 cycle after the last handshake.
- Backpressure: base=0x10, len=8, out_ready toggled 1,0,0,1,... Expect no word lost or duplicated, out_data stable while stalled, and rom_me never issued while credit is 0.
- Boundaries:
  - len=0: done pulses, rom_me is never asserted.
  - base=9622799, len=1: one read, accepted.
  - base=9622799, len=2: err pulses, no rom_me.
- Reset mid-command: base=0, len=100, reset asserted after 10 words. Next cycle expect out_valid=0, busy=0, rom_me=0; cmd_ready=1 after reset drops. A following command base=0x20, len=2 completes correctly.
- Back-to-back commands: cmd_valid held with a second command. It is accepted only after done; out_last appears exactly once per command.
- LSH_FETCH_PERF_EN: len=4 with out_ready low for 5 stalled cycles. Expect perf_stall_cycles=5.
